bus_mux_arbiter: RTL and testbench

Round-robin arbiter that shares the 32-bit three-source tri-state bus mux between three requesters: source 0, source 1 and source 2. It grants one requester at a time and drives the mux `sel` input. It inserts one dead turnaround cycle between owners so that two drivers never overlap. It also bounds the hold time of a contended grant. It sits in the processor datapath next to the bus mux, and its `sel` output connects directly to the mux `sel` port.

---
 rtl/bus_mux_arbiter.sv | 106 ++++++++++
 tb/tb_bus_mux_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bus_mux_arbiter.sv
// Round-robin owner arbiter for the three-source tri-state bus mux.
// Inserts one dead turnaround cycle between owners and bounds contended hold time.
//
// state | meaning
// IDLE  | no owner, arbitrate on any request
// GRANT | one owner (index in last) drives the bus
// TURN  | one dead cycle between owners, then arbitrate like IDLE
module bus_mux_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       preempt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    localparam logic [7:0] CNT_MAX = 8'(MAX_HOLD - 1);

    logic [1:0] state;
    logic [1:0] last;
    logic [7:0] cnt;
    logic [1:0] cand_1;
    logic [1:0] cand_2;
    logic [1:0] cand_3;
    logic [1:0] winner;
    logic [2:0] others;

    function automatic logic [1:0] next_idx(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Search starts just after the most recent owner, so it is always checked last.
    always_comb begin
        cand_1 = next_idx(last);
        cand_2 = next_idx(cand_1);
        cand_3 = next_idx(cand_2);
        winner = cand_3;
        if (req[cand_1]) begin
            winner = cand_1;
        end else if (req[cand_2]) begin
            winner = cand_2;
        end
        others = req & ~(3'b001 << last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 2'd2;
            cnt     <= 8'd0;
            grant   <= 3'b000;
            sel     <= 2'b11;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE, TURN: begin
                    if (|req) begin
                        state <= GRANT;
                        last  <= winner;
                        cnt   <= 8'd0;
                        grant <= 3'b001 << winner;
                        sel   <= winner;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        grant <= 3'b000;
                        sel   <= 2'b11;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[last]) begin
                        state <= TURN;
                        grant <= 3'b000;
                        sel   <= 2'b11;
                        busy  <= 1'b0;
                    end else if ((cnt == CNT_MAX) && (|others)) begin
                        state   <= TURN;
                        grant   <= 3'b000;
                        sel     <= 2'b11;
                        busy    <= 1'b0;
                        preempt <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 3'b000;
                    sel   <= 2'b11;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Directed-vector bench for bus_mux_arbiter; expected outputs are queued by the
// stimulus process and checked by an independent monitor one edge later.
module tb_bus_mux_arbiter;

    typedef struct packed {
        logic [2:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       preempt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    exp_t exp_q[$];
    int   id_q[$];
    int   step_no = 0;
    int   checks = 0;
    int   failures = 0;

    bus_mux_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] sel_of(input logic [2:0] g);
        case (g)
            3'b001:  return 2'b00;
            3'b010:  return 2'b01;
            3'b100:  return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [2:0] rq,
                        input logic [2:0] g, input logic p);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        req   = rq;
        e.grant   = g;
        e.sel     = sel_of(g);
        e.busy    = (g != 3'b000);
        e.preempt = p;
        step_no++;
        exp_q.push_back(e);
        id_q.push_back(step_no);
    endtask

    task automatic hold(input int n, input logic [2:0] rq, input logic [2:0] g);
        for (int i = 0; i < n; i++) step(1'b1, rq, g, 1'b0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        exp_t act;
        int   id;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            act = {grant, sel, busy, preempt};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL step%0d outputs{grant,sel,busy,preempt}: got %b_%b_%b_%b want %b_%b_%b_%b",
                         id, act.grant, act.sel, act.busy, act.preempt,
                         e.grant, e.sel, e.busy, e.preempt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        // Reset with all requests pending, then source 0 wins first.
        step(1'b0, 3'b111, 3'b000, 1'b0);
        step(1'b0, 3'b111, 3'b000, 1'b0);
        hold(8, 3'b111, 3'b001);
        // Contended round robin: 8-cycle holds, preempting turnarounds.
        step(1'b1, 3'b111, 3'b000, 1'b1);
        hold(8, 3'b111, 3'b010);
        step(1'b1, 3'b111, 3'b000, 1'b1);
        hold(8, 3'b111, 3'b100);
        step(1'b1, 3'b111, 3'b000, 1'b1);
        hold(8, 3'b111, 3'b001);
        step(1'b1, 3'b000, 3'b000, 1'b0);
        step(1'b1, 3'b000, 3'b000, 1'b0);

        // Single request, release, turnaround, idle.
        hold(5, 3'b010, 3'b010);
        step(1'b1, 3'b000, 3'b000, 1'b0);
        step(1'b1, 3'b000, 3'b000, 1'b0);

        // Uncontended owner holds past the limit without preemption.
        hold(20, 3'b100, 3'b100);
        step(1'b1, 3'b000, 3'b000, 1'b0);
        step(1'b1, 3'b000, 3'b000, 1'b0);

        // Owner 0 contended by 1, releases exactly on its limit edge.
        hold(8, 3'b011, 3'b001);
        step(1'b1, 3'b010, 3'b000, 1'b0);
        hold(2, 3'b010, 3'b010);

        // Mid-grant reset, then last=2 makes source 0 win over 1.
        step(1'b0, 3'b011, 3'b000, 1'b0);
        hold(2, 3'b011, 3'b001);
        step(1'b1, 3'b000, 3'b000, 1'b0);
        step(1'b1, 3'b000, 3'b000, 1'b0);

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
